// File: rtl/oric_pkg.sv
// Shared definitions for the ram_init_seq power-on RAM clear block:
// the sequencer state encoding and the default fill constants.
package oric_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } init_state_t;

  localparam logic [7:0] DEF_FILL      = 8'h01;
  localparam int         DEF_PAT_SHIFT = 7;

endpackage

// File: rtl/ram_init_seq.sv
// Power-on RAM clear sequencer: fills DEPTH words with FILL, then passes CPU requests through.
// Optional build macro RAM_INIT_PATTERN_EN stripes the fill data every 2**PAT_SHIFT words.
module ram_init_seq
  import oric_pkg::*;
#(
  parameter int              AW        = 16,
  parameter int              DW        = 8,
  parameter int              DEPTH     = 2**AW,
  parameter logic [DW-1:0]   FILL      = DW'(DEF_FILL),
  parameter int              PAT_SHIFT = DEF_PAT_SHIFT
) (
  input  logic          clk_sys,
  input  logic          RESET,
  input  logic          start,
  input  logic          clr_ce,
  input  logic [AW-1:0] cpu_ad,
  input  logic [DW-1:0] cpu_d,
  input  logic          cpu_cs,
  input  logic          cpu_we,
  output logic [AW-1:0] mem_ad,
  output logic [DW-1:0] mem_d,
  output logic          mem_cs,
  output logic          mem_we,
  output logic          busy,
  output logic          done,
  output logic          cpu_reset
);

  localparam int             CNT_W    = AW + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  init_state_t      state_r;
  init_state_t      state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             last_s;

  logic [AW-1:0]    mem_ad_s;
  logic [DW-1:0]    mem_d_s;
  logic             mem_cs_s;
  logic             mem_we_s;
  logic             busy_s;
  logic             done_s;
  logic [DW-1:0]    fill_s;

  // State and clear-address counter register
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      state_r <= ST_CLEAR;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and counter logic; a start always wins over completing the last write
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    last_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_CLEAR;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (start) begin
          cnt_nxt_s = {CNT_W{1'b0}};
        end else if (clr_ce) begin
          if (cnt_r == CNT_LAST) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = {CNT_W{1'b0}};
            last_s      = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: begin
        state_nxt_s = ST_CLEAR;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Fill data for the current clear address
  always_comb begin
`ifdef RAM_INIT_PATTERN_EN
    if (cnt_r[PAT_SHIFT]) begin
      fill_s = ~FILL;
    end else begin
      fill_s = FILL;
    end
`else
    fill_s = FILL;
`endif
  end

  // Next values of the registered RAM-side request and status outputs
  always_comb begin
    mem_ad_s = cpu_ad;
    mem_d_s  = cpu_d;
    mem_cs_s = cpu_cs;
    mem_we_s = cpu_we;
    case (state_r)
      ST_IDLE: begin
        mem_ad_s = cpu_ad;
        mem_d_s  = cpu_d;
        mem_cs_s = cpu_cs;
        mem_we_s = cpu_we;
      end
      ST_CLEAR: begin
        // A restart issues one non-writing cycle at address 0 before the new sweep
        if (start) begin
          mem_ad_s = {AW{1'b0}};
          mem_d_s  = FILL;
          mem_cs_s = 1'b1;
          mem_we_s = 1'b0;
        end else begin
          mem_ad_s = cnt_r[AW-1:0];
          mem_d_s  = fill_s;
          mem_cs_s = 1'b1;
          mem_we_s = clr_ce;
        end
      end
      default: begin
        mem_ad_s = {AW{1'b0}};
        mem_d_s  = {DW{1'b0}};
        mem_cs_s = 1'b0;
        mem_we_s = 1'b0;
      end
    endcase
    done_s = last_s;
    busy_s = (state_nxt_s == ST_CLEAR);
  end

  // Output register
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      mem_ad    <= {AW{1'b0}};
      mem_d     <= {DW{1'b0}};
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      busy      <= 1'b1;
      done      <= 1'b0;
      cpu_reset <= 1'b1;
    end else begin
      mem_ad    <= mem_ad_s;
      mem_d     <= mem_d_s;
      mem_cs    <= mem_cs_s;
      mem_we    <= mem_we_s;
      busy      <= busy_s;
      done      <= done_s;
      cpu_reset <= busy_s;
    end
  end

endmodule

// File: tb/tb_ram_init_seq.sv
// Directed self-checking bench for ram_init_seq with AW=4, DEPTH=16, FILL=01, PAT_SHIFT=2.
// Expected fill data follows RAM_INIT_PATTERN_EN when the bench is built with it.
module tb_ram_init_seq;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk_sys = 1'b0;
  logic          RESET;
  logic          start;
  logic          clr_ce;
  logic [AW-1:0] cpu_ad;
  logic [DW-1:0] cpu_d;
  logic          cpu_cs;
  logic          cpu_we;
  logic [AW-1:0] mem_ad;
  logic [DW-1:0] mem_d;
  logic          mem_cs;
  logic          mem_we;
  logic          busy;
  logic          done;
  logic          cpu_reset;

  int checks   = 0;
  int failures = 0;

  ram_init_seq #(
    .AW(AW), .DW(DW), .DEPTH(16), .FILL(8'h01), .PAT_SHIFT(2)
  ) dut (
    .clk_sys(clk_sys), .RESET(RESET), .start(start), .clr_ce(clr_ce),
    .cpu_ad(cpu_ad), .cpu_d(cpu_d), .cpu_cs(cpu_cs), .cpu_we(cpu_we),
    .mem_ad(mem_ad), .mem_d(mem_d), .mem_cs(mem_cs), .mem_we(mem_we),
    .busy(busy), .done(done), .cpu_reset(cpu_reset)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [7:0] exp_fill(input int a);
`ifdef RAM_INIT_PATTERN_EN
    return ((a >> 2) & 1) != 0 ? 8'hFE : 8'h01;
`else
    return 8'h01;
`endif
  endfunction

  // Full 16-write sweep with clr_ce high, starting on the next edge
  task automatic sweep(input string tag);
    for (int i = 0; i < 16; i++) begin
      tick();
      check_eq({tag, "_cs"}, 32'(mem_cs), 32'd1);
      check_eq({tag, "_we"}, 32'(mem_we), 32'd1);
      check_eq({tag, "_ad"}, 32'(mem_ad), 32'(i));
      check_eq({tag, "_d"}, 32'(mem_d), 32'(exp_fill(i)));
      check_eq({tag, "_done"}, 32'(done), (i == 15) ? 32'd1 : 32'd0);
      check_eq({tag, "_busy"}, 32'(busy), (i == 15) ? 32'd0 : 32'd1);
      check_eq({tag, "_cpurst"}, 32'(cpu_reset), (i == 15) ? 32'd0 : 32'd1);
    end
    tick();
    check_eq({tag, "_done_after"}, 32'(done), 32'd0);
    check_eq({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cs"}, 32'(mem_cs), 32'd0);
    check_eq({tag, "_we"}, 32'(mem_we), 32'd0);
    check_eq({tag, "_ad"}, 32'(mem_ad), 32'd0);
    check_eq({tag, "_d"}, 32'(mem_d), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_cpurst"}, 32'(cpu_reset), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    RESET  = 1'b1;
    start  = 1'b0;
    clr_ce = 1'b1;
    cpu_ad = 4'h0;
    cpu_d  = 8'h00;
    cpu_cs = 1'b0;
    cpu_we = 1'b0;

    // Reset held for three cycles, then the power-on clear
    for (int i = 0; i < 3; i++) tick();
    check_reset_outputs("rst");
    RESET = 1'b0;
    sweep("por");

    // Registered pass-through in IDLE
    cpu_ad = 4'hA; cpu_d = 8'h5C; cpu_cs = 1'b1; cpu_we = 1'b1;
    tick();
    check_eq("pt1_ad", 32'(mem_ad), 32'hA);
    check_eq("pt1_d", 32'(mem_d), 32'h5C);
    check_eq("pt1_cs", 32'(mem_cs), 32'd1);
    check_eq("pt1_we", 32'(mem_we), 32'd1);
    cpu_ad = 4'h3; cpu_d = 8'hA7; cpu_cs = 1'b1; cpu_we = 1'b0;
    check_eq("pt2_hold_ad", 32'(mem_ad), 32'hA);
    tick();
    check_eq("pt2_ad", 32'(mem_ad), 32'h3);
    check_eq("pt2_d", 32'(mem_d), 32'hA7);
    check_eq("pt2_we", 32'(mem_we), 32'd0);
    check_eq("pt2_busy", 32'(busy), 32'd0);

    // clr_ce toggling: writes only on enabled cycles, held address otherwise
    pulse_start();
    check_eq("tog_busy_rise", 32'(busy), 32'd1);
    check_eq("tog_pt_ad", 32'(mem_ad), 32'h3);
    for (int c = 0; c < 31; c++) begin
      clr_ce = ((c % 2) == 0);
      tick();
      check_eq("tog_we", 32'(mem_we), ((c % 2) == 0) ? 32'd1 : 32'd0);
      check_eq("tog_ad", 32'(mem_ad), 32'((c + 1) / 2));
      check_eq("tog_done", 32'(done), (c == 30) ? 32'd1 : 32'd0);
    end
    clr_ce = 1'b1;
    cpu_cs = 1'b0;
    tick();
    check_eq("tog_idle_busy", 32'(busy), 32'd0);

    // Restart with the counter at 9
    pulse_start();
    for (int i = 0; i < 9; i++) begin
      tick();
      check_eq("rs9_pre_ad", 32'(mem_ad), 32'(i));
    end
    pulse_start();
    check_eq("rs9_ad", 32'(mem_ad), 32'd0);
    check_eq("rs9_we", 32'(mem_we), 32'd0);
    check_eq("rs9_done", 32'(done), 32'd0);
    check_eq("rs9_busy", 32'(busy), 32'd1);
    sweep("rs9");

    // Restart coinciding with the final write
    pulse_start();
    for (int i = 0; i < 15; i++) begin
      tick();
      check_eq("rs15_pre_done", 32'(done), 32'd0);
    end
    pulse_start();
    check_eq("rs15_ad", 32'(mem_ad), 32'd0);
    check_eq("rs15_we", 32'(mem_we), 32'd0);
    check_eq("rs15_done", 32'(done), 32'd0);
    check_eq("rs15_busy", 32'(busy), 32'd1);
    sweep("rs15");

    // Reset asserted mid-clear at address 7
    pulse_start();
    for (int i = 0; i < 8; i++) tick();
    check_eq("mid_ad7", 32'(mem_ad), 32'd7);
    RESET = 1'b1;
    tick();
    check_reset_outputs("mid_rst");
    tick();
    RESET = 1'b0;
    sweep("mid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_init_seq.md
RAM_INIT_SEQ -- requirements
Module: ram_init_seq

Interface
REQ-001 SHALL have parameter AW, default 16: RAM address width.
REQ-002 SHALL have parameter DW, default 8: RAM data width.
REQ-003 SHALL have parameter DEPTH, default 2**AW: number of words cleared, 1..2**AW.
REQ-004 SHALL have parameter FILL, default 'h01: clear data word.
REQ-005 SHALL have parameter PAT_SHIFT, default 7: pattern half-period is 2**PAT_SHIFT words; used only with REQ-028.
REQ-006 SHALL have port clk_sys, input, 1: system clock, all logic on its rising edge.
REQ-007 SHALL have port RESET, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port start, input, 1: single-cycle request to begin or restart a clear.
REQ-009 SHALL have port clr_ce, input, 1: clear-advance enable; the address advances only in cycles where it is 1.
REQ-010 SHALL have ports cpu_ad/cpu_d/cpu_cs/cpu_we, inputs, AW/DW/1/1: CPU-side RAM request.
REQ-011 SHALL have ports mem_ad/mem_d/mem_cs/mem_we, outputs, AW/DW/1/1: registered RAM-side request.
REQ-012 SHALL have port busy, output, 1: high while in CLEAR.
REQ-013 SHALL have port done, output, 1: one-cycle pulse when a clear completes.
REQ-014 SHALL have port cpu_reset, output, 1: hold for the CPU core, equal to busy OR RESET, registered.

Function
REQ-015 SHALL implement the states IDLE and CLEAR.
REQ-016 In IDLE, mem_* SHALL equal the cpu_* values of the previous cycle (one-cycle latency, registered pass-through).
REQ-017 In CLEAR, mem_cs=1, mem_we=clr_ce, mem_ad=clear counter and mem_d=fill data SHALL be registered, and CPU requests SHALL be ignored.
REQ-018 The counter SHALL be AW+1 bits wide; it increments only when clr_ce=1 and holds otherwise.
REQ-019 When clr_ce=1 and the counter equals DEPTH-1, the state SHALL go to IDLE, done SHALL pulse 1 in the next cycle, and the counter SHALL return to 0.
REQ-020 With clr_ce tied high, a clear SHALL issue exactly DEPTH writes over DEPTH consecutive cycles, at addresses 0..DEPTH-1 in ascending order, with no gaps and no wrap-around.
REQ-021 A start in IDLE SHALL enter CLEAR with the counter at 0; the first write address appears on mem_ad the following cycle.
REQ-022 A start during CLEAR SHALL restart from address 0 without a done pulse.
REQ-023 If start coincides with the final write, the restart SHALL win and done SHALL NOT pulse.
REQ-024 busy SHALL rise in the cycle after entering CLEAR and fall in the same cycle that done pulses.

Reset
REQ-025 While RESET=1: state=CLEAR, counter=0, mem_cs=0, mem_we=0, mem_ad=0, mem_d=0, busy=1, done=0, cpu_reset=1.
REQ-026 On RESET release, the clear SHALL proceed from address 0; a RESET asserted mid-clear SHALL restart the clear after release.

Configuration
REQ-027 Without RAM_INIT_PATTERN_EN, the fill data SHALL be the constant FILL.
REQ-028 With RAM_INIT_PATTERN_EN, the fill data SHALL be FILL when counter bit PAT_SHIFT is 0, and ~FILL when it is 1 (striped power-on pattern).

Structure
REQ-029 The state enum and default FILL/PAT_SHIFT constants SHALL live in a shared package, oric_pkg.
REQ-030 The block SHALL be a single module with no sub-modules; the counter and state logic fit directly in it.

Verification
REQ-031 AW=4, DEPTH=16, FILL='h01, clr_ce=1, RESET high 3 cycles then low -> writes to addresses 0..15 with data 01; done pulses exactly once, 16 cycles after RESET release; busy then goes low.
REQ-032 In IDLE, cpu_ad='h0A, cpu_d='h5C, cpu_cs=1, cpu_we=1 -> mem_* shows the same values exactly one cycle later.
REQ-033 clr_ce toggling 1,0,1,0 during CLEAR -> addresses advance only on clr_ce=1 cycles, mem_we=0 on held cycles, and the clear takes 32 cycles.
REQ-034 start pulse while the counter is at 9 -> the next mem_ad is 0, there is no done pulse, and the full 16-write sequence follows; start on the last write (address 15) -> restart, no done pulse.
REQ-035 RAM_INIT_PATTERN_EN defined, PAT_SHIFT=2, FILL='h01 -> data sequence is 01×4, FE×4, 01×4, FE×4.
REQ-036 RESET asserted at address 7 -> outputs take the REQ-025 values, and after release the writes restart at address 0.
